truth_table_sweeper: RTL and testbench

Parametrised exhaustive truth-table stimulus-and-check engine for small combinational lab circuits. On a start request it drives every input combination of an N_IN-input unit under test in ascending binary order, holds each vector for a programmable number of cycles, samples the N_OUT-bit response and compares it with a packed expected truth table. It reports a mismatch count, the first failing vector and a pass/fail verdict. It sits beside the combinational block in a self-checking bench or on-board test harness, and replaces hand-written per-vector stimulus.

---
 rtl/truth_table_sweeper.sv | 152 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: drives every input combination of a small combinational
// unit under test in ascending order, holds each vector HOLD cycles, compares
// the response against a packed expected truth table and reports the verdict.
module truth_table_sweeper #(
    parameter int unsigned N_IN  = 3,
    parameter int unsigned N_OUT = 1,
    parameter int unsigned HOLD  = 5,
    parameter logic [(2**N_IN)*N_OUT-1:0] EXPECTED = 8'hE8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   stim,
    input  logic [N_OUT-1:0]  resp,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail,
    output logic              first_fail_valid
);

    localparam int unsigned V     = 2**N_IN;
    localparam int unsigned ERR_W = N_IN + 1;
    localparam int unsigned CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [N_IN-1:0]  LAST_VEC = N_IN'(V - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_IN-1:0]    stim_d;
    logic               busy_d;
    logic               done_d;
    logic               pass_d;
    logic [ERR_W-1:0]   err_d;
    logic [N_IN-1:0]    ff_d;
    logic               ffv_d;

    logic [N_OUT-1:0]   exp_slice;
    logic               mismatch;

    // Expected response slice for the vector currently on stim.
    always_comb begin
        exp_slice = N_OUT'(EXPECTED >> (32'(stim) * N_OUT));
        mismatch  = (resp != exp_slice);
    end

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stim_d  = stim;
        busy_d  = busy;
        done_d  = 1'b0;
        pass_d  = pass;
        err_d   = err_count;
        ff_d    = first_fail;
        ffv_d   = first_fail_valid;

        unique case (state_q)
            IDLE: begin
                stim_d = '0;
                busy_d = 1'b0;
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    ff_d    = '0;
                    ffv_d   = 1'b0;
                end
            end

            RUN: begin
                if (abort) begin
                    // Abort wins over a compare on the same edge.
                    state_d = IDLE;
                    cnt_d   = '0;
                    stim_d  = '0;
                    busy_d  = 1'b0;
                    pass_d  = 1'b0;
                end else if (cnt_q == LAST_CNT) begin
                    if (mismatch) begin
                        err_d = err_count + ERR_W'(1);
                        if (!first_fail_valid) begin
                            ff_d  = stim;
                            ffv_d = 1'b1;
                        end
                    end
                    cnt_d = '0;
                    if (stim == LAST_VEC) begin
                        state_d = DONE;
                        stim_d  = '0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        stim_d = stim + N_IN'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                stim_d  = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            stim             <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail       <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            stim             <= stim_d;
            busy             <= busy_d;
            done             <= done_d;
            pass             <= pass_d;
            err_count        <= err_d;
            first_fail       <= ff_d;
            first_fail_valid <= ffv_d;
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench: a default 3-input instance against majority / AND3 units,
// and a 4-input, 2-output, HOLD=1 instance against a faulty parity/AND4 unit.
module tb_truth_table_sweeper;

    logic clk;
    logic rst_n;

    // Instance A: defaults (N_IN=3, N_OUT=1, HOLD=5, majority table).
    logic       start_a, abort_a;
    logic [2:0] stim_a;
    logic [0:0] resp_a;
    logic       busy_a, done_a, pass_a, ffv_a;
    logic [3:0] err_a;
    logic [2:0] ff_a;
    bit         uut_and3;

    // Instance B: bit0 = AND4, bit1 = odd-parity bit (1 when the input has an
    // even number of ones). Table per vector v: {parity(v), and4(v)}.
    logic       start_b, abort_b;
    logic [3:0] stim_b;
    logic [1:0] resp_b;
    logic       busy_b, done_b, pass_b, ffv_b;
    logic [4:0] err_b;
    logic [3:0] ff_b;

    int n_checks = 0;
    int n_pass   = 0;

    truth_table_sweeper u_dut_a (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_a),
        .abort            (abort_a),
        .stim             (stim_a),
        .resp             (resp_a),
        .busy             (busy_a),
        .done             (done_a),
        .pass             (pass_a),
        .err_count        (err_a),
        .first_fail       (ff_a),
        .first_fail_valid (ffv_a)
    );

    truth_table_sweeper #(
        .N_IN     (4),
        .N_OUT    (2),
        .HOLD     (1),
        .EXPECTED (32'hC228_2882)
    ) u_dut_b (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start_b),
        .abort            (abort_b),
        .stim             (stim_b),
        .resp             (resp_b),
        .busy             (busy_b),
        .done             (done_b),
        .pass             (pass_b),
        .err_count        (err_b),
        .first_fail       (ff_b),
        .first_fail_valid (ffv_b)
    );

    // Combinational units under test.
    always_comb begin
        if (uut_and3)
            resp_a[0] = stim_a[2] & stim_a[1] & stim_a[0];
        else
            resp_a[0] = (stim_a[2] & stim_a[1]) | (stim_a[2] & stim_a[0]) | (stim_a[1] & stim_a[0]);
        resp_b[0] = &stim_b;
        resp_b[1] = (stim_b == 4'd15) ? 1'b0 : ~^stim_b;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic check_a_zero(input string tag);
        check({tag, "_stim"}, 32'(stim_a), 32'd0);
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_done"}, 32'(done_a), 32'd0);
        check({tag, "_pass"}, 32'(pass_a), 32'd0);
        check({tag, "_err"},  32'(err_a),  32'd0);
        check({tag, "_ff"},   32'(ff_a),   32'd0);
        check({tag, "_ffv"},  32'(ffv_a),  32'd0);
    endtask

    task automatic pulse_start_a();
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
    endtask

    // Full sweep on instance A; optionally re-pulse start during vector 4.
    task automatic run_sweep_a(input string tag, input bit inject, input int exp_err,
                               input int exp_ff, input bit exp_ffv, input bit exp_pass);
        int cyc;
        pulse_start_a();
        cyc = 0;
        while (busy_a && cyc < 200) begin
            check({tag, "_stim"}, 32'(stim_a), 32'(cyc / 5));
            start_a = (inject && cyc == 22);
            cyc++;
            @(negedge clk);
        end
        start_a = 1'b0;
        check({tag, "_busy_cycles"}, 32'(cyc), 32'd40);
        check({tag, "_done"},  32'(done_a), 32'd1);
        check({tag, "_pass"},  32'(pass_a), 32'(exp_pass));
        check({tag, "_err"},   32'(err_a),  32'(exp_err));
        check({tag, "_ff"},    32'(ff_a),   32'(exp_ff));
        check({tag, "_ffv"},   32'(ffv_a),  32'(exp_ffv));
        check({tag, "_stim_end"}, 32'(stim_a), 32'd0);
        @(negedge clk);
        check({tag, "_done_1cyc"}, 32'(done_a), 32'd0);
        check({tag, "_idle"},      32'(busy_a), 32'd0);
    endtask

    // Start a sweep on A and abort it while sitting at cycle abort_cyc.
    task automatic run_abort_a(input string tag, input int abort_cyc, input int exp_err);
        int cyc;
        pulse_start_a();
        cyc = 0;
        while (busy_a && cyc < abort_cyc) begin
            cyc++;
            @(negedge clk);
        end
        check({tag, "_stim_pre"}, 32'(stim_a), 32'(abort_cyc / 5));
        abort_a = 1'b1;
        @(negedge clk) abort_a = 1'b0;
        check({tag, "_busy"}, 32'(busy_a), 32'd0);
        check({tag, "_stim"}, 32'(stim_a), 32'd0);
        check({tag, "_pass"}, 32'(pass_a), 32'd0);
        check({tag, "_err"},  32'(err_a),  32'(exp_err));
        repeat (4) begin
            check({tag, "_no_done"}, 32'(done_a), 32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        rst_n    = 1'b0;
        start_a  = 1'b0;
        abort_a  = 1'b0;
        start_b  = 1'b0;
        abort_b  = 1'b0;
        uut_and3 = 1'b0;

        // Reset values.
        repeat (3) @(negedge clk);
        check_a_zero("rst_a");
        check("rst_b_busy", 32'(busy_b), 32'd0);
        check("rst_b_err",  32'(err_b),  32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Majority UUT against majority table: clean pass.
        run_sweep_a("maj", 1'b0, 0, 0, 1'b0, 1'b1);

        // Abort during vector 2.
        run_abort_a("abort_v2", 10, 0);

        // AND3 UUT: vectors 3, 5, 6 fail; stray start at vector 4 is ignored.
        uut_and3 = 1'b1;
        run_sweep_a("and3", 1'b1, 3, 3, 1'b1, 1'b0);

        // Abort on the compare edge of failing vector 3: that compare is dropped.
        run_abort_a("abort_cmp", 19, 0);
        check("abort_cmp_ffv", 32'(ffv_a), 32'd0);

        // Asynchronous reset during vector 5.
        pulse_start_a();
        cyc = 0;
        while (busy_a && cyc < 27) begin
            cyc++;
            @(negedge clk);
        end
        check("pre_rst_stim", 32'(stim_a), 32'd5);
        check("pre_rst_err",  32'(err_a),  32'd1);
        check("pre_rst_ff",   32'(ff_a),   32'd3);
        #2 rst_n = 1'b0;
        #1 check_a_zero("async_rst");
        @(negedge clk) rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            check("post_rst_busy", 32'(busy_a), 32'd0);
            check("post_rst_stim", 32'(stim_a), 32'd0);
        end

        // Instance B: stuck bit at vector 15 gives a single failure.
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        cyc = 0;
        while (busy_b && cyc < 100) begin
            check("b_stim", 32'(stim_b), 32'(cyc));
            cyc++;
            @(negedge clk);
        end
        check("b_busy_cycles", 32'(cyc), 32'd16);
        check("b_done", 32'(done_b), 32'd1);
        check("b_err",  32'(err_b),  32'd1);
        check("b_ff",   32'(ff_b),   32'd15);
        check("b_ffv",  32'(ffv_b),  32'd1);
        check("b_pass", 32'(pass_b), 32'd0);
        @(negedge clk);
        check("b_done_1cyc", 32'(done_b), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
